mem_wr_stager: RTL and testbench



---
 rtl/mem_wr_stager_pkg.sv | 21 ++
 rtl/mem_wr_stager_fifo.sv | 49 ++++
 rtl/mem_wr_stager.sv | 92 +++++++++
 tb/tb_mem_wr_stager.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wr_stager_pkg.sv
// Shared types and helpers for the masked register-array write stager.
package mem_wr_stager_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned STAT_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } wr_req_t;

  // Bits with mask=1 take the new data, the rest keep the old word.
  function automatic logic [DATA_W-1:0] merge_bits(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] data,
                                                   input logic [DATA_W-1:0] mask);
    return (old_word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/mem_wr_stager_fifo.sv
// Request FIFO for the write stager; pointers carry an extra wrap bit to
// tell full from empty.
module mem_wr_stager_fifo
  import mem_wr_stager_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  wr_req_t        push_req,
  input  logic           pop,
  output wr_req_t        head_c,
  output logic           full_c,
  output logic           empty_c,
  output logic [PTR_W:0] level_c
);

  logic [PTR_W:0] wptr;
  logic [PTR_W:0] rptr;
  wr_req_t        mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign full_c  = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign empty_c = (wptr == rptr);
  assign level_c = wptr - rptr;
  assign head_c  = mem[rptr[PTR_W-1:0]];

  // A full FIFO refuses pushes even when it pops on the same edge.
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PTR_W+1)'(1);
      if (do_pop)  rptr <= rptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PTR_W-1:0]] <= push_req;
  end

endmodule

// File: rtl/mem_wr_stager.sv
// Masked write stager: queues bit-masked requests, merges them against a
// shadow copy of the array and drives full-word writes to the consumer.
// Optional MEM_WR_STAGER_STATS_EN adds pop and stall counters.
module mem_wr_stager
  import mem_wr_stager_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_mask,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_din,
  output logic [LVL_W-1:0]  level
`ifdef MEM_WR_STAGER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_writes,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam int unsigned WORDS = 2 ** ADDR_W;

  wr_req_t           push_req;
  wr_req_t           head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] shadow [WORDS];

  assign push_req = '{addr: in_addr, data: in_data, mask: in_mask};
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && !wr_stall;
  assign merged   = merge_bits(shadow[head.addr], head.data, head.mask);

  mem_wr_stager_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head_c   (head),
    .full_c   (full),
    .empty_c  (empty),
    .level_c  (level)
  );

  // Shadow updates on the pop edge so back-to-back requests to one word chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_din  <= '0;
      for (int i = 0; i < int'(WORDS); i++) shadow[i] <= '0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        wr_addr             <= head.addr;
        wr_din              <= merged;
        shadow[head.addr]   <= merged;
      end
    end
  end

`ifdef MEM_WR_STAGER_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_writes <= '0;
      stat_stall  <= '0;
    end else begin
      if (pop && (stat_writes != '1))
        stat_writes <= stat_writes + STAT_W'(1);
      if (!empty && wr_stall && (stat_stall != '1))
        stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wr_stager.sv
// Self-checking bench for mem_wr_stager: vector table plus multi-cycle
// sequences, with a write scoreboard checked on every wr_en.
module tb_mem_wr_stager;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_addr;
  logic [7:0] in_data;
  logic [7:0] in_mask;
  logic       wr_stall;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_din;
  logic [2:0] level;
`ifdef MEM_WR_STAGER_STATS_EN
  logic [15:0] stat_writes;
  logic [15:0] stat_stall;
`endif

  mem_wr_stager #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .wr_stall (wr_stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_din   (wr_din),
    .level    (level)
`ifdef MEM_WR_STAGER_STATS_EN
    ,
    .stat_writes (stat_writes),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] din;
  } exp_t;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp_din;
  } vec_t;

  exp_t       sb [$];
  exp_t       mon_e;
  logic [7:0] mshadow [4];
  int         n_vec = 0;
  int         n_err = 0;
  vec_t       vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_merge(input logic [1:0] a, input logic [7:0] d,
                                             input logic [7:0] m);
    return (mshadow[a] & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) mshadow[i] = 8'h00;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [1:0] a, input logic [7:0] d, input logic [7:0] m,
                      input logic [7:0] exp_din);
    int waited = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_mask  = m;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 at %0t", $time);
    end else begin
      sb.push_back('{addr: a, din: exp_din});
      mshadow[a] = exp_din;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_remaining", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d din %h expected no write at %0t",
                 wr_addr, wr_din, $time);
      end else begin
        mon_e = sb.pop_front();
        check("write_addr_din", 32'({wr_addr, wr_din}), 32'({mon_e.addr, mon_e.din}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'd2, 8'h00, 8'hFF, 8'h00};
    vecs[1]  = '{2'd2, 8'hFF, 8'h0F, 8'h0F};
    vecs[2]  = '{2'd2, 8'h00, 8'h03, 8'h0C};
    vecs[3]  = '{2'd0, 8'h3C, 8'hFF, 8'h3C};
    vecs[4]  = '{2'd0, 8'hFF, 8'h0F, 8'h3F};
    vecs[5]  = '{2'd0, 8'h00, 8'hF0, 8'h0F};
    vecs[6]  = '{2'd3, 8'hAA, 8'h00, 8'h00};
    vecs[7]  = '{2'd3, 8'h55, 8'hFF, 8'h55};
    vecs[8]  = '{2'd3, 8'hF0, 8'hAA, 8'hF5};
    vecs[9]  = '{2'd1, 8'h12, 8'hFF, 8'h12};
    vecs[10] = '{2'd0, 8'h81, 8'h81, 8'h8F};

    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_mask = '0; wr_stall = 1'b0;
    model_reset();
    #2;
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_din", 32'(wr_din), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_level", 32'(level), 32'd0);
    end

    // Single full-mask write latency.
    push(2'd1, 8'hA5, 8'hFF, 8'hA5);
    check("lat_edge1_wr_en", 32'(wr_en), 32'd0);
    check("lat_edge1_level", 32'(level), 32'd1);
    @(negedge clk);
    check("lat_edge2_wr_en", 32'(wr_en), 32'd1);
    check("lat_edge2_wr_addr", 32'(wr_addr), 32'd1);
    check("lat_edge2_wr_din", 32'(wr_din), 32'hA5);
    @(negedge clk);
    check("lat_edge3_wr_en", 32'(wr_en), 32'd0);
    check("lat_hold_wr_din", 32'(wr_din), 32'hA5);

    // Back-to-back table vectors, merges checked by the scoreboard.
    for (int i = 0; i < 11; i++)
      push(vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].exp_din);
    drain();

    // Stall fills the FIFO.
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      push(2'd1, 8'h10 + 8'(i), 8'hFF, 8'h10 + 8'(i));
    check("stall_level", 32'(level), 32'd4);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_addr = 2'd3; in_data = 8'hEE; in_mask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_full_hold_level", 32'(level), 32'd4);
      check("stall_no_write", 32'(wr_en), 32'd0);
    end
    in_valid = 1'b0;
    wr_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("release_consecutive_wr_en", 32'(wr_en), 32'd1);
    end
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_level", 32'(level), 32'd0);
    @(negedge clk);
    check("release_done_wr_en", 32'(wr_en), 32'd0);

    // Reset while requests are queued.
    wr_stall = 1'b1;
    push(2'd3, 8'h77, 8'hFF, model_merge(2'd3, 8'h77, 8'hFF));
    push(2'd3, 8'h00, 8'h0F, model_merge(2'd3, 8'h00, 8'h0F));
    push(2'd2, 8'h11, 8'hFF, model_merge(2'd2, 8'h11, 8'hFF));
    wr_stall = 1'b0;
    @(negedge clk);
    check("pre_reset_wr_en", 32'(wr_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_wr_en", 32'(wr_en), 32'd0);
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_no_write", 32'(wr_en), 32'd0);
    end
    // Shadow words are zero again after reset.
    push(2'd3, 8'hFF, 8'h00, 8'h00);
    push(2'd2, 8'h5A, 8'h0F, 8'h0A);
    drain();

`ifdef MEM_WR_STAGER_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_stall = 1'b1;
    push(2'd0, 8'h01, 8'hFF, 8'h01);
    repeat (3) @(negedge clk);
    wr_stall = 1'b0;
    for (int i = 0; i < 4; i++)
      push(2'd1, 8'h20 + 8'(i), 8'hFF, 8'h20 + 8'(i));
    drain();
    @(negedge clk);
    check("stat_writes", 32'(stat_writes), 32'd5);
    check("stat_stall", 32'(stat_stall), 32'd3);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
